// File: rtl/bird_sprite_reader.sv
// bird_sprite_reader
//   Fetches pixels of a SPR_W x SPR_H sprite from an external single-port ROM
//   as the raster scan passes over the sprite's box. Fixed 3-cycle latency,
//   no stall: one scan position accepted every clock.
//
// Ports
//   clka, rsta_n        : clock and synchronous active-low reset
//   frame_start         : one-cycle pulse; latches bird_x/bird_y for the frame
//   bird_x, bird_y      : sprite top-left corner (screen coordinates)
//   pix_valid/x/y       : current scan position (active video when pix_valid)
//   rom_addra           : registered sprite ROM address
//   rom_doa             : ROM data, valid the cycle after rom_addra is sampled
//   pix_out             : opaque sprite pixel, else 0
//   pix_hit             : pix_out carries an opaque sprite pixel
//   pix_out_valid       : pix_valid delayed by 3 cycles
module bird_sprite_reader #(
    parameter int                SPR_W     = 45,
    parameter int                SPR_H     = 45,
    parameter int                ADDR_W    = 11,
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] KEY_COLOR = 16'hF81F
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              frame_start,
    input  logic [9:0]        bird_x,
    input  logic [9:0]        bird_y,
    input  logic              pix_valid,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    output logic [ADDR_W-1:0] rom_addra,
    input  logic [DATA_W-1:0] rom_doa,
    output logic [DATA_W-1:0] pix_out,
    output logic              pix_hit,
    output logic              pix_out_valid
);

    localparam int STAGES = 3;
    localparam int PW     = 21;              // product width: 11-bit row * up to 10-bit width
    localparam logic [PW-1:0] W_CONST = PW'(SPR_W);

    // Constant shift-add multiply by SPR_W; unrolls into an adder tree over
    // the set bits of SPR_W only.
    function automatic logic [PW-1:0] mul_w(input logic [9:0] v);
        logic [PW-1:0] r;
        logic [PW-1:0] ext;
        r   = '0;
        ext = PW'(v);
        for (int i = 0; i < PW; i++) begin
            if (W_CONST[i]) r = r + (ext << i);
        end
        return r;
    endfunction

    logic [9:0]  bx_q, by_q;
    logic [10:0] bx_end, by_end;
    logic        in_box;
    logic [9:0]  dx, dy;
    logic [PW-1:0] offs;

    // Valid and in-box delay lines; index k holds the value k cycles old.
    logic [STAGES-1:1] vld_pipe;
    logic [STAGES-1:1] box_pipe;

    // 11-bit box edges so a sprite near the right/bottom screen edge does
    // not wrap back to column/row 0.
    assign bx_end = {1'b0, bx_q} + 11'(SPR_W - 1);
    assign by_end = {1'b0, by_q} + 11'(SPR_H - 1);

    assign in_box = pix_valid
                 && (pix_x >= bx_q) && ({1'b0, pix_x} <= bx_end)
                 && (pix_y >= by_q) && ({1'b0, pix_y} <= by_end);

    assign dx   = pix_x - bx_q;
    assign dy   = pix_y - by_q;
    assign offs = mul_w(dy) + PW'(dx);

    // Position latch. A pixel arriving together with frame_start still sees
    // the old position because stage 1 reads bx_q/by_q before this update.
    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            bx_q <= '0;
            by_q <= '0;
        end else if (frame_start) begin
            bx_q <= bird_x;
            by_q <= bird_y;
        end
    end

    // Stage 1: address; stage 2: wait for ROM; stage 3: key test and output.
    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            rom_addra     <= '0;
            vld_pipe      <= '0;
            box_pipe      <= '0;
            pix_out       <= '0;
            pix_hit       <= 1'b0;
            pix_out_valid <= 1'b0;
        end else begin
            rom_addra     <= in_box ? offs[ADDR_W-1:0] : '0;
            vld_pipe      <= {vld_pipe[STAGES-2:1], pix_valid};
            box_pipe      <= {box_pipe[STAGES-2:1], in_box};
            pix_out_valid <= vld_pipe[STAGES-1];
            pix_hit       <= box_pipe[STAGES-1] && (rom_doa != KEY_COLOR);
            pix_out       <= (box_pipe[STAGES-1] && (rom_doa != KEY_COLOR))
                             ? rom_doa : '0;
        end
    end

endmodule

// File: tb/tb_bird_sprite_reader.sv
module tb_bird_sprite_reader;

    localparam int SPR_W = 45;
    localparam int SPR_H = 45;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;
    localparam logic [15:0] KEY = 16'hF81F;
    localparam int NCYC = 8192;

    logic              clka = 1'b0;
    logic              rsta_n;
    logic              frame_start;
    logic [9:0]        bird_x, bird_y;
    logic              pix_valid;
    logic [9:0]        pix_x, pix_y;
    logic [ADDR_W-1:0] rom_addra;
    logic [DATA_W-1:0] rom_doa;
    logic [DATA_W-1:0] pix_out;
    logic              pix_hit;
    logic              pix_out_valid;

    bird_sprite_reader #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .KEY_COLOR(KEY)
    ) dut (
        .clka(clka), .rsta_n(rsta_n), .frame_start(frame_start),
        .bird_x(bird_x), .bird_y(bird_y), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .rom_addra(rom_addra), .rom_doa(rom_doa),
        .pix_out(pix_out), .pix_hit(pix_hit), .pix_out_valid(pix_out_valid)
    );

    always #5 clka = ~clka;

    // Sprite ROM: data appears the cycle after the address is sampled.
    logic [15:0] rom [0:2047];
    always @(posedge clka) rom_doa <= rom[rom_addra];

    // Expected values indexed by cycle number.
    int          exp_addr [NCYC];
    logic [15:0] exp_out  [NCYC];
    logic        exp_hit  [NCYC];
    logic        exp_vld  [NCYC];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mbx = 0, mby = 0;   // model of the latched sprite position

    task automatic check_now();
        checks++;
        assert (int'(rom_addra) === exp_addr[cyc]) else begin
            errors++;
            $error("FAIL addr cyc=%0d got=%0d exp=%0d", cyc, rom_addra, exp_addr[cyc]);
        end
        checks++;
        assert (pix_out_valid === exp_vld[cyc]) else begin
            errors++;
            $error("FAIL valid cyc=%0d got=%0b exp=%0b", cyc, pix_out_valid, exp_vld[cyc]);
        end
        checks++;
        assert (pix_hit === exp_hit[cyc]) else begin
            errors++;
            $error("FAIL hit cyc=%0d got=%0b exp=%0b", cyc, pix_hit, exp_hit[cyc]);
        end
        checks++;
        assert (pix_out === exp_out[cyc]) else begin
            errors++;
            $error("FAIL out cyc=%0d got=%h exp=%h", cyc, pix_out, exp_out[cyc]);
        end
    endtask

    // Present one cycle of input, record what the block must produce, clock, check.
    task automatic step(input bit rn, input bit fs, input int bxi, input int byi,
                        input bit pv, input int px, input int py);
        bit inb;
        int a;
        logic [15:0] d;
        rsta_n = rn; frame_start = fs;
        bird_x = 10'(bxi); bird_y = 10'(byi);
        pix_valid = pv; pix_x = 10'(px); pix_y = 10'(py);
        inb = pv && px >= mbx && px < mbx + SPR_W && py >= mby && py < mby + SPR_H;
        a = inb ? ((py - mby) * SPR_W + (px - mbx)) % 2048 : 0;
        d = rom[a];
        if (rn) begin
            exp_addr[cyc+1] = a;
            exp_vld[cyc+3]  = pv;
            exp_hit[cyc+3]  = inb && d != KEY;
            exp_out[cyc+3]  = (inb && d != KEY) ? d : 16'h0;
        end else begin
            // Reset: everything in flight and this cycle's pixel is dropped.
            exp_addr[cyc+1] = 0;
            for (int k = 1; k <= 3; k++) begin
                exp_vld[cyc+k] = 1'b0; exp_hit[cyc+k] = 1'b0; exp_out[cyc+k] = 16'h0;
            end
        end
        @(posedge clka);
        if (!rn) begin mbx = 0; mby = 0; end
        else if (fs) begin mbx = bxi; mby = byi; end
        #1;
        cyc++;
        check_now();
    endtask

    initial begin
        for (int i = 0; i < NCYC; i++) begin
            exp_addr[i] = 0; exp_out[i] = 16'h0; exp_hit[i] = 1'b0; exp_vld[i] = 1'b0;
        end
        for (int i = 0; i < 2048; i++)
            rom[i] = ($urandom_range(0, 7) == 0) ? KEY : 16'($urandom);
        rom[0]    = 16'h1234;
        rom[2024] = 16'hBEEF;
        rom[232]  = KEY;       // (107,55) relative to box at (100,50)
        rom[23]   = 16'h0F0F;
        rsta_n = 1'b0; frame_start = 1'b0; bird_x = '0; bird_y = '0;
        pix_valid = 1'b0; pix_x = '0; pix_y = '0;

        // Reset state
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // Basic fetch, corners, just outside, keyed pixel
        step(1, 1, 100, 50, 0, 0, 0);
        step(1, 0, 100, 50, 1, 100, 50);
        step(1, 0, 100, 50, 1, 144, 94);
        step(1, 0, 100, 50, 1, 145, 94);
        step(1, 0, 100, 50, 1, 99, 50);
        step(1, 0, 100, 50, 1, 107, 55);
        step(1, 0, 100, 50, 0, 120, 60);
        // Mid-frame move has no effect until frame_start
        step(1, 0, 200, 50, 1, 150, 60);
        step(1, 0, 200, 50, 1, 200, 50);
        // frame_start together with a pixel: pixel uses the old box
        step(1, 1, 200, 50, 1, 100, 50);
        step(1, 0, 200, 50, 1, 200, 50);
        step(1, 0, 200, 50, 1, 100, 50);
        // Right screen edge, no wrap
        step(1, 1, 1000, 50, 0, 0, 0);
        step(1, 0, 1000, 50, 1, 1023, 50);
        step(1, 0, 1000, 50, 1, 5, 50);
        step(1, 0, 1000, 50, 1, 1000, 94);
        // Continuous stream with a 1-cycle reset in the middle
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 1, 1000 + i, 50 + i);
        step(0, 0, 0, 0, 1, 1010, 52);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1, i, i);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);

        // Randomized frames; scan positions biased around the sprite box
        for (int n = 0; n < 3000; n++) begin
            int bx, by, px, py;
            bit fs, pv, rn;
            bx = $urandom_range(0, 1023);
            by = $urandom_range(0, 1023);
            fs = ($urandom_range(0, 40) == 0);
            rn = ($urandom_range(0, 150) != 0);
            pv = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 3) == 0) begin
                px = $urandom_range(0, 1023);
                py = $urandom_range(0, 1023);
            end else begin
                px = (mbx + $urandom_range(0, SPR_W + 3) + 1022) % 1024;
                py = (mby + $urandom_range(0, SPR_H + 3) + 1022) % 1024;
            end
            step(rn, fs, bx, by, pv, px, py);
        end
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bird_sprite_reader.md
BIRD_SPRITE_READER -- requirements
Module: bird_sprite_reader

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- SPR_W, 45, sprite width in pixels.
- SPR_H, 45, sprite height in pixels.
- ADDR_W, 11, sprite ROM address width.
- DATA_W, 16, pixel width (RGB565).
- KEY_COLOR, 16'hF81F, transparent colour.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clka, in, 1: single clock; all logic on rising edge.
- rsta_n, in, 1: reset, synchronous, active-low.
- frame_start, in, 1: one-cycle pulse at start of each video frame.
- bird_x, in, 10: sprite top-left column.
- bird_y, in, 10: sprite top-left row.
- pix_valid, in, 1: pix_x/pix_y valid this cycle (active video).
- pix_x, in, 10: current scan column.
- pix_y, in, 10: current scan row.
- rom_addra, out, ADDR_W: address to the single-port sprite ROM.
- rom_doa, in, DATA_W: ROM read data, valid the cycle after rom_addra is sampled (unregistered ROM output).
- pix_out, out, DATA_W: sprite pixel.
- pix_hit, out, 1: pix_out is an opaque sprite pixel.
- pix_out_valid, out, 1: delayed pix_valid.
REQ-003 Clock is clka; reset is rsta_n, synchronous and active-low; no other clock or asynchronous reset SHALL exist.

Function
REQ-004 Position latch: on a cycle with frame_start=1, bird_x/bird_y SHALL be captured into bx_q/by_q; the latched values SHALL be used for the whole frame, so mid-frame bird_x/bird_y changes have no effect until the next frame_start.
REQ-005 If frame_start and pix_valid are both high in the same cycle, that pixel SHALL use the old bx_q/by_q; the new values apply from the next cycle.
REQ-006 In-box test (stage 1): in_box = pix_valid AND (pix_x >= bx_q) AND (pix_x <= bx_q+SPR_W-1) AND (pix_y >= by_q) AND (pix_y <= by_q+SPR_H-1). Compare in 11 bits so bx_q+SPR_W-1 > 1023 cannot wrap.
REQ-007 Address (stage 1): when in_box=1, rom_addra SHALL register (pix_y-by_q)*SPR_W + (pix_x-bx_q), truncated to ADDR_W; maximum is SPR_W*SPR_H-1 = 2024. When in_box=0, rom_addra SHALL register 0.
REQ-008 Multiplication by SPR_W SHALL use constant shift-add or a row-base accumulator; no generic multiplier is required.
REQ-009 Pipeline: inputs presented in cycle t give rom_addra in cycle t+1 and rom_doa in cycle t+2. pix_out, pix_hit and pix_out_valid SHALL be registered and valid in cycle t+3; the fixed latency is 3 cycles. in_box and pix_valid SHALL be delayed to match.
REQ-010 Output stage: pix_out_valid = pix_valid delayed 3 cycles; pix_hit = in_box(delayed) AND (rom_doa != KEY_COLOR); pix_out = rom_doa when pix_hit=1, else 0.
REQ-011 The pipeline SHALL have no stall: one pixel per cycle is accepted, and pix_valid=0 cycles flow through as bubbles with pix_out_valid=0 and pix_hit=0.
REQ-012 Edge cases: a sprite partially off-screen (bx_q > 1023-SPR_W+1) SHALL show its visible part only; pix_x=bx_q+SPR_W (one past the right edge) SHALL give pix_hit=0.

Reset
REQ-013 While rsta_n=0 at a clock edge, every register SHALL clear: bx_q=0, by_q=0, rom_addra=0, pix_out=0, pix_hit=0, pix_out_valid=0, and all delay-line valid/in_box bits=0.
REQ-014 Reset asserted mid-line SHALL discard in-flight pixels: no pix_out_valid=1 for 3 cycles after rsta_n returns high, unless new pix_valid input arrives.

Verification
REQ-015 Scenario: frame_start with bird_x=100, bird_y=50; then pix (100,50) -> rom_addra=0 at t+1; ROM data 16'h1234 gives pix_out=16'h1234, pix_hit=1 at t+3.
REQ-016 Scenario: same frame, pix (144,94) -> rom_addra=2024; pix (145,94) and (99,50) -> rom_addra=0, pix_hit=0.
REQ-017 Scenario: in-box pixel whose ROM word = 16'hF81F -> pix_hit=0, pix_out=0, pix_out_valid=1.
REQ-018 Scenario: bird_x changes 100->200 mid-frame without frame_start -> box stays at column 100; after the next frame_start, pix (200,50) -> rom_addra=0.
REQ-019 Scenario: bird_x=1000, pix (1023,50) -> rom_addra=23, pix_hit per ROM data; pix (5,50) -> pix_hit=0 (no wrap).
REQ-020 Scenario: continuous pix_valid stream, rsta_n low for 1 cycle mid-stream -> all outputs 0 in the following cycle; output resumes with exactly 3-cycle latency.
